div_multicycle: RTL and testbench

- Multi-cycle radix-2 (restoring) divider for the EX stage of the 5-stage MIPS pipeline.
- Sits directly downstream of the ALU decoder. EX starts it when the decoded ALU control is DIV_OP (signed) or DIVU_OP (unsigned).
- Asserts a stall while iterating. Returns quotient (to LO) and remainder (to HI) with a one-cycle done pulse for the HI/LO write.

---
 rtl/div_if.sv | 40 ++++
 rtl/div_multicycle.sv | 233 +++++++++++++++++++++++
 tb/tb_div_multicycle.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// -----------------------------------------------------------------------------
// div_if
//   Request/response bundle between the EX stage and the multi-cycle divider.
//
//   Signals (from the EX stage / master point of view):
//     start       out  request a divide (sampled by the divider only when idle)
//     signed_div  out  1 = DIV (two's complement), 0 = DIVU
//     opdata1     out  dividend (rs)
//     opdata2     out  divisor  (rt)
//     annul       out  flush request, aborts any operation in flight
//     result_lo   in   quotient  (to LO), valid only while done=1
//     result_hi   in   remainder (to HI), valid only while done=1
//     done        in   one-cycle pulse, results valid
//     stall_div   in   combinational pipeline stall request
// -----------------------------------------------------------------------------
interface div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_div;
  logic [WIDTH-1:0] opdata1;
  logic [WIDTH-1:0] opdata2;
  logic             annul;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             done;
  logic             stall_div;

  // EX stage side: issues requests, consumes results.
  modport master (
    output start, signed_div, opdata1, opdata2, annul,
    input  result_lo, result_hi, done, stall_div
  );

  // Divider side.
  modport slave (
    input  start, signed_div, opdata1, opdata2, annul,
    output result_lo, result_hi, done, stall_div
  );
endinterface

// File: rtl/div_multicycle.sv
// -----------------------------------------------------------------------------
// div_multicycle
//   Radix-2 restoring divider for the EX stage. One quotient bit is produced
//   per clock, so a divide takes WIDTH iterations. Signed divides are done on
//   magnitudes and the signs are fixed up when the last iteration completes,
//   so the result registers already hold final values in the DONE cycle.
//
//   Ports:
//     clk   in   rising-edge clock
//     rst   in   synchronous, active-high reset (priority over everything)
//     bus   div_if.slave
//             start/signed_div/opdata1/opdata2 latched when accepted in IDLE
//             annul forces IDLE at the next edge, suppresses done immediately
//             result_lo/result_hi registered quotient/remainder
//             done one-cycle pulse, stall_div combinational stall request
//
//   Timing: start accepted in cycle 0, done in cycle WIDTH+1.
//           Divide by zero skips iteration and signals done in cycle 1 with
//           quotient = all ones and remainder = the untouched dividend.
// -----------------------------------------------------------------------------
module div_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;

  // Iteration state: remainder accumulator, dividend/quotient shift register,
  // divisor magnitude and iteration counter.
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] divisor_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             neg_q_reg;
  logic             neg_r_reg;

  // Final results, held until overwritten by the next completed divide.
  logic [WIDTH-1:0] result_lo_reg;
  logic [WIDTH-1:0] result_hi_reg;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic             accept;
  logic             div_zero;
  logic             op1_neg;
  logic             op2_neg;
  logic [WIDTH-1:0] op1_abs;
  logic [WIDTH-1:0] op2_abs;

  assign accept   = bus.start && !bus.annul;
  assign div_zero = (bus.opdata2 == '0);

  // Only a signed request treats the MSB as a sign. The magnitude of the most
  // negative value negates to itself, which read as unsigned is exactly
  // 2^(WIDTH-1), so no special case is needed.
  assign op1_neg  = bus.signed_div && bus.opdata1[WIDTH-1];
  assign op2_neg  = bus.signed_div && bus.opdata2[WIDTH-1];
  assign op1_abs  = op1_neg ? (-bus.opdata1) : bus.opdata1;
  assign op2_abs  = op2_neg ? (-bus.opdata2) : bus.opdata2;

  // ---------------------------------------------------------------------------
  // One restoring iteration
  // ---------------------------------------------------------------------------
  // Shift {rem, quo} left by one and trial-subtract the divisor from the upper
  // WIDTH+1 bits. The extra bit is needed because the shifted remainder can
  // reach 2*divisor-1, which may not fit in WIDTH bits.
  logic [WIDTH:0]   partial;
  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] quo_fixed;
  logic [WIDTH-1:0] rem_fixed;

  assign partial  = {rem_reg, quo_reg[WIDTH-1]};
  assign trial    = partial - {1'b0, divisor_reg};
  assign q_bit    = ~trial[WIDTH];
  // On a non-negative trial the difference is below the divisor and fits in
  // WIDTH bits; on a negative trial the partial itself is below the divisor.
  assign rem_step = q_bit ? trial[WIDTH-1:0] : partial[WIDTH-1:0];
  assign quo_step = {quo_reg[WIDTH-2:0], q_bit};

  // Sign fix-up applied to the values produced by the last iteration.
  // Negating a zero remainder yields zero, so a zero remainder never turns
  // into a "negative zero".
  assign quo_fixed = neg_q_reg ? (-quo_step) : quo_step;
  assign rem_fixed = neg_r_reg ? (-rem_step) : rem_step;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    if (bus.annul) begin
      // Flush wins over any start and over completion.
      state_next = IDLE;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_next = div_zero ? DONE : BUSY;
          end
        end
        BUSY: begin
          if (cnt_reg == LAST_ITER) begin
            state_next = DONE;
          end
        end
        DONE: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // The stall drops in the DONE cycle so the EX/MEM register can capture the
  // results while done is high. An annul in DONE kills the pulse that cycle.
  always_comb begin
    bus.done      = 1'b0;
    bus.stall_div = 1'b0;
    unique case (state_reg)
      IDLE: begin
        bus.stall_div = accept;
      end
      BUSY: begin
        bus.stall_div = 1'b1;
      end
      DONE: begin
        bus.done = !bus.annul;
      end
      default: begin
        bus.done      = 1'b0;
        bus.stall_div = 1'b0;
      end
    endcase
  end

  assign bus.result_lo = result_lo_reg;
  assign bus.result_hi = result_hi_reg;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_reg       <= '0;
      quo_reg       <= '0;
      divisor_reg   <= '0;
      cnt_reg       <= '0;
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
      result_lo_reg <= '0;
      result_hi_reg <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (accept) begin
            if (div_zero) begin
              // Defined divide-by-zero result; the dividend is passed through
              // as given, without taking its magnitude.
              result_lo_reg <= '1;
              result_hi_reg <= bus.opdata1;
            end else begin
              rem_reg     <= '0;
              quo_reg     <= op1_abs;
              divisor_reg <= op2_abs;
              neg_q_reg   <= op1_neg ^ op2_neg;
              neg_r_reg   <= op1_neg;
              cnt_reg     <= '0;
            end
          end
        end
        BUSY: begin
          // An annulled iteration is simply dropped; the state register
          // returns to IDLE and the result registers keep their old value.
          if (!bus.annul) begin
            rem_reg <= rem_step;
            quo_reg <= quo_step;
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == LAST_ITER) begin
              result_lo_reg <= quo_fixed;
              result_hi_reg <= rem_fixed;
            end
          end
        end
        default: begin
          // DONE: results are held for the consumer.
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol properties
  // ---------------------------------------------------------------------------
  // done is never high in two consecutive cycles.
  assert property (@(posedge clk) disable iff (rst) bus.done |=> !bus.done);

  // The pipeline is never stalled while results are being handed over.
  assert property (@(posedge clk) disable iff (rst) !(bus.done && bus.stall_div));

endmodule

// File: tb/tb_div_multicycle.sv
`timescale 1ns/1ps
module tb_div_multicycle;

  logic clk;
  logic rst;

  div_if #(.WIDTH(32)) bus ();

  div_multicycle #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic [7:0]  lat;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called 1 ns after a rising edge; that cycle becomes cycle 0.
  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    bit seen;
    int stall_bad;
    bus.start      = 1'b1;
    bus.signed_div = v.sgn;
    bus.opdata1    = v.a;
    bus.opdata2    = v.b;
    @(negedge clk);
    check($sformatf("v%0d stall_c0", idx), 32'(bus.stall_div), 32'd1);
    check($sformatf("v%0d done_c0", idx), 32'(bus.done), 32'd0);
    step();
    // Scramble the inputs: an operation in flight must not see them.
    bus.start      = 1'b0;
    bus.signed_div = ~v.sgn;
    bus.opdata1    = ~v.a;
    bus.opdata2    = v.b + 32'd1;
    cyc       = 1;
    seen      = 1'b0;
    stall_bad = 0;
    while (!seen && cyc <= int'(v.lat) + 4) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (!bus.stall_div) stall_bad++;
        step();
        cyc++;
      end
    end
    if (!seen) $display("FAIL v%0d timeout: no done within %0d cycles", idx, cyc);
    check($sformatf("v%0d latency", idx), 32'(cyc), 32'(v.lat));
    check($sformatf("v%0d stall_busy", idx), 32'(stall_bad), 32'd0);
    check($sformatf("v%0d lo", idx), bus.result_lo, v.lo);
    check($sformatf("v%0d hi", idx), bus.result_hi, v.hi);
    check($sformatf("v%0d stall_done", idx), 32'(bus.stall_div), 32'd0);
    $display("vec %0d: %s %h / %h -> lo=%h hi=%h done_cycle=%0d",
             idx, v.sgn ? "DIV " : "DIVU", v.a, v.b, bus.result_lo, bus.result_hi, cyc);
    step();
    @(negedge clk);
    check($sformatf("v%0d done_pulse", idx), 32'(bus.done), 32'd0);
    step();
  endtask

  // Counts done pulses over n cycles with idle inputs.
  task automatic count_done(input int n, output int dones);
    dones = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (bus.done) dones++;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    int dcyc;
    logic [31:0] dlo, dhi;

    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.opdata1    = '0;
    bus.opdata2    = '0;
    bus.annul      = 1'b0;

    // sgn, a, b, lo, hi, lat
    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          8'd33};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   8'd33};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          8'd33};
    vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          8'd33};
    vecs[4]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          8'd33};
    vecs[5]  = '{1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          8'd33};
    vecs[6]  = '{1'b0, 32'h1234,       32'd0,          32'hFFFFFFFF,   32'h1234,       8'd1};
    vecs[7]  = '{1'b1, 32'h1234,       32'd0,          32'hFFFFFFFF,   32'h1234,       8'd1};
    vecs[8]  = '{1'b1, 32'hFFFFFFF0,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF0,   8'd1};
    vecs[9]  = '{1'b1, 32'hFFFFFFFA,   32'd3,          32'hFFFFFFFE,   32'd0,          8'd33};
    vecs[10] = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   8'd33};
    vecs[11] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   8'd33};
    vecs[12] = '{1'b0, 32'hFFFFFFFF,   32'h10,         32'h0FFFFFFF,   32'hF,          8'd33};

    // Reset state
    step();
    step();
    @(negedge clk);
    check("rst lo", bus.result_lo, 32'd0);
    check("rst hi", bus.result_hi, 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst stall", 32'(bus.stall_div), 32'd0);
    step();
    rst = 1'b0;

    // Table-driven divides
    for (int i = 0; i < 13; i++) begin
      run_vec(vecs[i], i);
    end

    // Annul at cycle 10 of a divide
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.opdata1 = 32'd1000; bus.opdata2 = 32'd3;
    step();
    bus.start = 1'b0;
    repeat (9) step();
    bus.annul = 1'b1;
    @(negedge clk);
    check("annul done_c10", 32'(bus.done), 32'd0);
    step();
    bus.annul = 1'b0;
    @(negedge clk);
    check("annul idle_c11", 32'(bus.stall_div), 32'd0);
    step();
    count_done(40, dones);
    check("annul no_done", 32'(dones), 32'd0);
    $display("seq annul_busy: done pulses after annul=%0d", dones);
    run_vec('{1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 8'd33}, 100);

    // Annul in the DONE cycle of a divide by zero
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.opdata1 = 32'd20; bus.opdata2 = 32'd0;
    step();
    bus.start = 1'b0;
    bus.annul = 1'b1;
    @(negedge clk);
    check("annul_done suppressed", 32'(bus.done), 32'd0);
    step();
    bus.annul = 1'b0;
    count_done(5, dones);
    check("annul_done none_later", 32'(dones), 32'd0);
    $display("seq annul_done: done pulses=%0d", dones);

    // Start together with annul is ignored
    bus.start = 1'b1; bus.annul = 1'b1; bus.opdata1 = 32'd9; bus.opdata2 = 32'd3;
    @(negedge clk);
    check("start_annul stall", 32'(bus.stall_div), 32'd0);
    step();
    bus.start = 1'b0; bus.annul = 1'b0;
    @(negedge clk);
    check("start_annul not_busy", 32'(bus.stall_div), 32'd0);
    step();
    $display("seq start_with_annul: stall=%0d", bus.stall_div);

    // Reset at cycle 15 of a divide
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.opdata1 = 32'd100; bus.opdata2 = 32'd7;
    step();
    bus.start = 1'b0;
    repeat (14) step();
    rst = 1'b1;
    step();
    @(negedge clk);
    check("midrst lo", bus.result_lo, 32'd0);
    check("midrst hi", bus.result_hi, 32'd0);
    check("midrst done", 32'(bus.done), 32'd0);
    check("midrst stall", 32'(bus.stall_div), 32'd0);
    step();
    rst = 1'b0;
    count_done(40, dones);
    check("midrst no_done", 32'(dones), 32'd0);
    $display("seq reset_mid_op: done pulses=%0d lo=%h", dones, bus.result_lo);

    // Starts while BUSY and in DONE are ignored
    dones = 0; dcyc = -1; dlo = '0; dhi = '0;
    for (int c = 0; c < 50; c++) begin
      if (c == 0) begin
        bus.start = 1'b1; bus.signed_div = 1'b0; bus.opdata1 = 32'd100; bus.opdata2 = 32'd7;
      end else if (c == 5 || c == 20 || c == 33) begin
        bus.start = 1'b1; bus.signed_div = 1'b1; bus.opdata1 = 32'd200; bus.opdata2 = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (bus.done) begin
        dones++;
        dcyc = c;
        dlo  = bus.result_lo;
        dhi  = bus.result_hi;
      end
      step();
    end
    bus.start = 1'b0;
    check("ignstart dones", 32'(dones), 32'd1);
    check("ignstart cycle", 32'(dcyc), 32'd33);
    check("ignstart lo", dlo, 32'd14);
    check("ignstart hi", dhi, 32'd2);
    $display("seq ignored_start: dones=%0d cycle=%0d lo=%h hi=%h", dones, dcyc, dlo, dhi);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
